// File: rtl/multicycle_exec_core.sv
// Multi-cycle execution core: accepts one instruction at a time and steps it through
// IDLE -> DECODE -> EXECUTE -> WRITEBACK against an internal register file with a debug port.
module multicycle_exec_core #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              wb_en,
  output logic [RA_W-1:0]   wb_reg,
  output logic              ovf,
  output logic              illegal,
  input  logic              dbg_we,
  input  logic [RA_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_ADDI,
    OP_ANDI,
    OP_ILL
  } opc_t;

  localparam int MSB = DATA_W - 1;

  state_t r_state;
  state_t w_next;

  // Only the instruction fields the core consumes are captured; rd and funct live inside imm.
  logic [5:0]        r_opf;
  logic [RA_W-1:0]   r_rs;
  logic [RA_W-1:0]   r_rt;
  logic [15:0]       r_imm16;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;
  opc_t              r_op;
  logic [RA_W-1:0]   r_dest;

  logic [DATA_W-1:0] r_result;
  logic              r_ovf;
  logic              r_illegal;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [RA_W-1:0]   w_rd;
  logic [5:0]        w_funct;
  opc_t              w_dec_op;
  logic [RA_W-1:0]   w_dec_dest;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_alu;
  logic              w_ovf;
  logic              w_wb_en;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (instr_valid) w_next = S_DECODE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wb_en       = 1'b0;
    ovf         = 1'b0;
    illegal     = 1'b0;
    unique case (r_state)
      S_IDLE:      instr_ready = 1'b1;
      S_DECODE:    busy = 1'b1;
      S_EXECUTE:   busy = 1'b1;
      S_WRITEBACK: begin
        busy    = 1'b1;
        done    = 1'b1;
        wb_en   = w_wb_en;
        ovf     = r_ovf;
        illegal = r_illegal;
      end
      default: ;
    endcase
  end

  assign w_wb_en   = !r_illegal && (r_dest != '0);
  assign result    = r_result;
  assign wb_reg    = r_dest;
  assign dbg_rdata = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  assign w_rd    = r_imm16[11 +: RA_W];
  assign w_funct = r_imm16[5:0];

  always_comb begin
    w_dec_op   = OP_ILL;
    w_dec_dest = r_rt;
    w_imm_ext  = DATA_W'($signed(r_imm16));
    unique case (r_opf)
      6'b000000: begin
        w_dec_dest = w_rd;
        unique case (w_funct)
          6'b100000: w_dec_op = OP_ADD;
          6'b100010: w_dec_op = OP_SUB;
          6'b100100: w_dec_op = OP_AND;
          6'b100101: w_dec_op = OP_OR;
          6'b101010: w_dec_op = OP_SLT;
          default:   w_dec_op = OP_ILL;
        endcase
      end
      6'b001000: w_dec_op = OP_ADDI;
      6'b001100: begin
        w_dec_op  = OP_ANDI;
        w_imm_ext = DATA_W'(r_imm16);
      end
      default: w_dec_op = OP_ILL;
    endcase
  end

  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_alu = r_a + r_b;
        w_ovf = (r_a[MSB] == r_b[MSB]) && (w_alu[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_alu = r_a - r_b;
        w_ovf = (r_a[MSB] != r_b[MSB]) && (w_alu[MSB] != r_a[MSB]);
      end
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
      OP_ADDI: begin
        w_alu = r_a + r_imm;
        w_ovf = (r_a[MSB] == r_imm[MSB]) && (w_alu[MSB] != r_a[MSB]);
      end
      OP_ANDI: w_alu = r_a & r_imm;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opf     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_imm16   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_op      <= OP_ILL;
      r_dest    <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_opf   <= instr[31:26];
            r_rs    <= instr[21 +: RA_W];
            r_rt    <= instr[16 +: RA_W];
            r_imm16 <= instr[15:0];
          end
        end
        S_DECODE: begin
          r_a    <= r_regs[r_rs];
          r_b    <= r_regs[r_rt];
          r_imm  <= w_imm_ext;
          r_op   <= w_dec_op;
          r_dest <= w_dec_dest;
        end
        S_EXECUTE: begin
          r_result  <= w_alu;
          r_ovf     <= w_ovf;
          r_illegal <= (r_op == OP_ILL);
        end
        default: ;
      endcase
    end
  end

  // r0 is never written, so it reads zero through both the datapath and the debug port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_WRITEBACK) begin
      if (w_wb_en) r_regs[r_dest] <= r_result;
    end else if (r_state == S_IDLE && dbg_we && dbg_addr != '0) begin
      r_regs[dbg_addr] <= dbg_wdata;
    end
  end

endmodule

// File: tb/tb_multicycle_exec_core.sv
// Directed bench: a 32-bit/32-reg core and a 16-bit/8-reg core run the same instruction stream in lockstep.
module tb_multicycle_exec_core;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] b_wdata;
  logic [15:0] s_wdata;

  logic        b_ready, b_busy, b_done, b_wb_en, b_ovf, b_ill;
  logic [31:0] b_result, b_rdata;
  logic [4:0]  b_wb_reg;

  logic        s_ready, s_busy, s_done, s_wb_en, s_ovf, s_ill;
  logic [15:0] s_result, s_rdata;
  logic [2:0]  s_wb_reg;

  int checks = 0;
  int errors = 0;

  multicycle_exec_core #(.DATA_W(32), .NUM_REGS(32)) u_big (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(b_ready), .busy(b_busy), .done(b_done), .result(b_result),
    .wb_en(b_wb_en), .wb_reg(b_wb_reg), .ovf(b_ovf), .illegal(b_ill),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(b_wdata), .dbg_rdata(b_rdata)
  );

  multicycle_exec_core #(.DATA_W(16), .NUM_REGS(8)) u_small (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(s_ready), .busy(s_busy), .done(s_done), .result(s_result),
    .wb_en(s_wb_en), .wb_reg(s_wb_reg), .ovf(s_ovf), .illegal(s_ill),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr[2:0]), .dbg_wdata(s_wdata), .dbg_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] addr, input logic [31:0] bval, input logic [15:0] sval);
    dbg_we = 1'b1; dbg_addr = addr; b_wdata = bval; s_wdata = sval;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] bexp,
                      input logic [15:0] sexp);
    dbg_addr = addr;
    #1;
    chk({tag, ".big"}, b_rdata, bexp);
    chk({tag, ".small"}, {16'h0, s_rdata}, {16'h0, sexp});
  endtask

  task automatic exec(input string tag, input logic [31:0] iw, input logic [31:0] bres,
                      input logic [15:0] sres, input logic wben, input logic [4:0] wbreg,
                      input logic ov, input logic il, input bit chkres);
    chk({tag, ".ready"}, {31'h0, b_ready & s_ready}, 32'd1);
    instr = iw; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({tag, ".busy"}, {30'h0, b_busy, s_busy}, 32'd3);
    chk({tag, ".nready"}, {30'h0, b_ready, s_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".done"}, {30'h0, b_done, s_done}, 32'd3);
    if (chkres) begin
      chk({tag, ".res.big"}, b_result, bres);
      chk({tag, ".res.small"}, {16'h0, s_result}, {16'h0, sres});
    end
    chk({tag, ".wb_en"}, {30'h0, b_wb_en, s_wb_en}, {30'h0, wben, wben});
    chk({tag, ".wb_reg.big"}, {27'h0, b_wb_reg}, {27'h0, wbreg});
    chk({tag, ".wb_reg.small"}, {29'h0, s_wb_reg}, {29'h0, wbreg[2:0]});
    chk({tag, ".ovf"}, {30'h0, b_ovf, s_ovf}, {30'h0, ov, ov});
    chk({tag, ".illegal"}, {30'h0, b_ill, s_ill}, {30'h0, il, il});
    @(posedge clk); #1;
    chk({tag, ".idle"}, {28'h0, b_done, s_done, b_ready, s_ready}, 32'h3);
  endtask

  initial begin
    int acc;
    int dn;
    reset = 1'b1; instr = '0; instr_valid = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; b_wdata = '0; s_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {30'h0, b_ready, s_ready}, 32'd3);
    chk("rst.flags", {28'h0, b_busy, b_done, b_wb_en, b_ovf}, 32'd0);
    chk("rst.flags_s", {28'h0, s_busy, s_done, s_wb_en, s_ovf}, 32'd0);
    chk("rst.illegal", {30'h0, b_ill, s_ill}, 32'd0);
    chk("rst.result", b_result, 32'd0);
    chk("rst.result_s", {16'h0, s_result}, 32'd0);
    chk("rst.wb_reg", {24'h0, b_wb_reg, s_wb_reg}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Case 1
    preload(5'd1, 32'd5, 16'd5);
    preload(5'd2, 32'd10, 16'd10);
    peek("pre.r2", 5'd2, 32'd10, 16'd10);
    exec("addi", 32'h2022000A, 32'd15, 16'd15, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1);
    peek("addi.r2", 5'd2, 32'd15, 16'd15);

    // Case 2 and other R-type/I-type operations
    exec("add", 32'h00221820, 32'd20, 16'd20, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    peek("add.r3", 5'd3, 32'd20, 16'd20);
    exec("sub", 32'h00223022, 32'hFFFFFFF6, 16'hFFF6, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
    peek("sub.r6", 5'd6, 32'hFFFFFFF6, 16'hFFF6);
    exec("slt_t", 32'h00C1382A, 32'd1, 16'd1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    peek("slt_t.r7", 5'd7, 32'd1, 16'd1);
    exec("slt_f", 32'h0026382A, 32'd0, 16'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    exec("and", 32'h00221824, 32'd5, 16'd5, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    exec("or", 32'h00221825, 32'd15, 16'd15, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    exec("andi", 32'h30C38F0F, 32'h00008F06, 16'h8F06, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    exec("addi_neg", 32'h2023FFFF, 32'd4, 16'd4, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);

    // Case 3: overflow behaviour
    preload(5'd4, 32'h7FFFFFFF, 16'h7FFF);
    exec("addi_ovf", 32'h20850001, 32'h80000000, 16'h8000, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    peek("addi_ovf.r5", 5'd5, 32'h80000000, 16'h8000);
    exec("sub_ovf", 32'h00A13022, 32'h7FFFFFFB, 16'h7FFB, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    exec("add_noovf", 32'h00853020, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);

    // Case 4: r0 destination, illegal opcode and funct, debug write to r0
    exec("addi_r0", 32'h2020000A, 32'd15, 16'd15, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    peek("addi_r0.r0", 5'd0, 32'd0, 16'd0);
    exec("ill_op", 32'hFC221820, 32'd0, 16'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0);
    peek("ill_op.r2", 5'd2, 32'd15, 16'd15);
    exec("ill_fn", 32'h00221821, 32'd0, 16'd0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    peek("ill_fn.r3", 5'd3, 32'd4, 16'd4);
    preload(5'd0, 32'h55, 16'h55);
    peek("dbg_r0", 5'd0, 32'd0, 16'd0);

    // Case 5: reset while in EXECUTE
    instr = 32'h2022000A; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid.done", {30'h0, b_done, s_done}, 32'd0);
    chk("rst_mid.ready", {28'h0, b_ready, s_ready, b_busy, s_busy}, 32'hC);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("rst_mid.regs", b_rdata, 32'd0);
      if (i < 8) chk("rst_mid.regs_s", {16'h0, s_rdata}, 32'd0);
    end
    @(posedge clk); #1;
    chk("rst_mid.stay_idle", {30'h0, b_done, b_wb_en}, 32'd0);

    // Case 6: debug write ignored while busy
    preload(5'd1, 32'd5, 16'd5);
    instr = 32'h2022000A; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    dbg_we = 1'b1; dbg_addr = 5'd1; b_wdata = 32'h99; s_wdata = 16'h99;
    repeat (2) @(posedge clk);
    #1;
    dbg_we = 1'b0;
    chk("busy_dbg.res", b_result, 32'd15);
    @(posedge clk); #1;
    peek("busy_dbg.r1", 5'd1, 32'd5, 16'd5);
    peek("busy_dbg.r2", 5'd2, 32'd15, 16'd15);

    // Debug write on the accept edge is visible to that instruction's DECODE
    dbg_we = 1'b1; dbg_addr = 5'd1; b_wdata = 32'd7; s_wdata = 16'd7;
    instr = 32'h00221820; instr_valid = 1'b1;
    @(posedge clk); #1;
    dbg_we = 1'b0; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("dbg_same_edge.res", b_result, 32'd22);
    chk("dbg_same_edge.res_s", {16'h0, s_result}, 32'd22);
    @(posedge clk); #1;

    // instr_valid held continuously: one accept per IDLE cycle
    acc = 0; dn = 0;
    instr = 32'h2022000A; instr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (b_ready) acc++;
      if (b_done) dn++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("held.accepts", 32'(acc), 32'd2);
    chk("held.dones", 32'(dn), 32'd2);
    chk("held.idle", {30'h0, b_ready, s_ready}, 32'd3);
    peek("held.r2", 5'd2, 32'd17, 16'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
